pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed per-stage latches between the CPU's decode, execute, memory and writeback stages. It carries a generic control/data payload together with the PC, the exception code and the branch-delay flag, using a valid/ready handshake instead of a global lock. It supports flush (bubble insertion) and an optional skid entry that registers the upstream ready path. A saturating stall counter gives per-stage performance visibility.

## Interface
Parameters:
- DATA_W, 64, payload width (operands plus the packed control bundle)
- EX_W, 5, exception code width
- RESET_PC, 32'h0000_3000, PC value presented while reset is asserted and after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept
- in_pc  in  32  entry PC
- in_data  in  DATA_W  entry payload
- in_ex  in  EX_W  exception code; 0 means no exception
- in_bd  in  1  entry sits in a branch-delay slot
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_pc  out  32  presented PC
- out_data  out  DATA_W  presented payload
- out_ex  out  EX_W  presented exception code
- out_bd  out  1  presented delay-slot flag
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Entry fields (pc, data, ex, bd) move as one unit and are never split.
- Main slot: drives the out_* ports.
- Skid slot: present only when PIPE_SKID_EN is defined.
- Occupancy states:
  - EMPTY: no slot valid.
  - ONE: main slot valid.
  - FULL: main and skid slots valid (skid build only).
- Transitions with skid:
  - EMPTY + in → ONE.
  - ONE + in + out → ONE (new entry loads main).
  - ONE + in, no out → FULL (new entry loads skid).
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE (skid moves to main).
  - in_ready = 0 in FULL, so FULL never accepts.
- flush=1 has the highest priority:
  - Next state is EMPTY.
  - An in-transfer in the same cycle completes at the handshake level and its entry is dropped.
  - out_data, out_ex and out_bd clear to 0. out_pc keeps its value.
- Invalid slots hold data 0, ex 0, bd 0.
- stall_cnt increments when out_valid && !out_ready, saturates at 16'hFFFF, and is cleared only by reset. flush does not clear it.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_pc=RESET_PC, out_data=0, out_ex=0, out_bd=0, stall_cnt=0.
  - State is EMPTY. in_ready is 1 from the first cycle after release.
- Latency: an accepted entry appears on out_* in the next cycle.
- Throughput: one entry per cycle while out_ready=1.
- Without skid: in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- With skid: in_ready = !skid_valid, driven directly from a flop with no combinational path from out_ready.
- Reset asserted mid-transfer: the entry is lost and all outputs immediately take their reset values.
- Outputs are stable while out_valid && !out_ready, apart from stall_cnt.

## Configuration
- PIPE_SKID_EN defined: two-entry stage, registered in_ready, FULL state exists.
- PIPE_SKID_EN undefined: single slot, combinational in_ready, states EMPTY/ONE only.
- Port list is identical in both builds.

## Structure
- Shared package pipe_pkg:
  - EX_NONE = 0
  - default EX_W
  - RESET_PC constant
  - packed entry typedef pipe_entry_t {pc, data, ex, bd}, parametrised by DATA_W through the module
- Sub-module pipe_slot:
  - One entry register with load, clear and valid.
  - Instantiated once, plus once more for the skid slot when PIPE_SKID_EN is defined.

## Test plan
- Reset: hold reset_n=0 with in_valid=1 → out_valid=0, out_pc=32'h3000, stall_cnt=0. After release, the first entry pc=32'h3004 appears one cycle after acceptance.
- Streaming: ten back-to-back entries with out_ready=1 → ten outputs on consecutive cycles, in order, with all fields intact.
- Back-pressure (skid build): out_ready=0 while two entries are offered → state FULL and in_ready=0. Then out_ready=1 → both entries emerge in order with none lost. stall_cnt equals the number of stalled cycles.
- Flush: FULL or ONE state, flush=1 while in_valid=1 → next cycle out_valid=0 and out_ex=0, out_pc unchanged, incoming entry dropped.
- Exception fields: in_ex=5'd12, in_bd=1 → out_ex=5'd12 and out_bd=1 on the same output cycle as the entry's pc.
- Saturation: hold out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and it does not wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage register (pipe_stage_reg)
// and its entry slots. The optional skid entry is enabled with PIPE_SKID_EN.
package pipe_pkg;

  localparam int unsigned PC_W             = 32;
  localparam int unsigned EX_W_DEFAULT     = 5;
  localparam int unsigned EX_NONE          = 0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register with a valid flag. Clear wins over load, and
// on clear only the bits selected by KEEP_MASK survive.
module pipe_slot #(
  parameter int unsigned  W         = 8,
  parameter logic [W-1:0] RST_VAL   = '0,
  parameter logic [W-1:0] KEEP_MASK = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic [W-1:0] entry_q, entry_d;
  logic         valid_q, valid_d;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (clear_i) begin
      entry_d = entry_q & KEEP_MASK;
      valid_d = 1'b0;
    end else if (load_i) begin
      entry_d = d_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying pc, payload, exception code and
// delay-slot flag. Defining PIPE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned EX_W     = EX_W_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EX_W-1:0]   in_ex,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EX_W-1:0]   out_ex,
  output logic              out_bd,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EX_W-1:0]   ex;
    logic              bd;
  } pipe_entry_t;

  localparam int unsigned ENTRY_W = $bits(pipe_entry_t);
  // The main slot keeps its pc when emptied so out_pc stays meaningful.
  localparam logic [ENTRY_W-1:0] MAIN_RST = {RESET_PC, {(ENTRY_W-PC_W){1'b0}}};
  localparam logic [ENTRY_W-1:0] PC_KEEP  = {{PC_W{1'b1}}, {(ENTRY_W-PC_W){1'b0}}};

  pipe_entry_t        inEntry, mainEntry;
  logic [ENTRY_W-1:0] mainD, mainQ;
  logic               mainLoad, mainClear, mainValid;
  logic               inXfer, outXfer;
  logic [15:0]        stallCnt_q, stallCnt_d;

  assign inEntry = '{pc: in_pc, data: in_data, ex: in_ex, bd: in_bd};
  assign inXfer  = in_valid && in_ready;
  assign outXfer = mainValid && out_ready;

  pipe_slot #(
    .W        (ENTRY_W),
    .RST_VAL  (MAIN_RST),
    .KEEP_MASK(PC_KEEP)
  ) uMainSlot (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (mainLoad),
    .clear_i(mainClear),
    .d_i    (mainD),
    .q_o    (mainQ),
    .valid_o(mainValid)
  );

`ifdef PIPE_SKID_EN
  logic               skidLoad, skidClear, skidValid;
  logic [ENTRY_W-1:0] skidQ;
  occ_e               occ;

  pipe_slot #(
    .W        (ENTRY_W),
    .RST_VAL  ('0),
    .KEEP_MASK('0)
  ) uSkidSlot (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (skidLoad),
    .clear_i(skidClear),
    .d_i    (inEntry),
    .q_o    (skidQ),
    .valid_o(skidValid)
  );

  assign in_ready = !skidValid;

  always_comb begin
    occ       = skidValid ? OCC_FULL : (mainValid ? OCC_ONE : OCC_EMPTY);
    mainD     = inEntry;
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: mainLoad = inXfer;
        OCC_ONE: begin
          mainLoad  = inXfer && outXfer;
          skidLoad  = inXfer && !outXfer;
          mainClear = outXfer && !inXfer;
        end
        OCC_FULL: begin
          mainD     = skidQ;
          mainLoad  = outXfer;
          skidClear = outXfer;
        end
        default: ;
      endcase
    end
  end
`else
  assign in_ready = !mainValid || out_ready;

  always_comb begin
    mainD     = inEntry;
    mainLoad  = inXfer;
    mainClear = flush || (outXfer && !inXfer);
  end
`endif

  assign stallCnt_d = (mainValid && !out_ready && stallCnt_q != 16'hFFFF)
                      ? stallCnt_q + 16'd1 : stallCnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stallCnt_q <= 16'd0;
    else          stallCnt_q <= stallCnt_d;
  end

  assign mainEntry = pipe_entry_t'(mainQ);
  assign out_valid = mainValid;
  assign out_pc    = mainEntry.pc;
  assign out_data  = mainEntry.data;
  assign out_ex    = mainEntry.ex;
  assign out_bd    = mainEntry.bd;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a queue model of the stage;
// capacity follows PIPE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0;
  logic [63:0] in_data = 64'd0;
  logic [4:0]  in_ex = 5'd0;
  logic        in_bd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [63:0] out_data;
  logic [4:0]  out_ex;
  logic        out_bd;
  logic [15:0] stall_cnt;

  pipe_stage_reg dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_data  (in_data),
    .in_ex    (in_ex),
    .in_bd    (in_bd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_data (out_data),
    .out_ex   (out_ex),
    .out_bd   (out_bd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic [4:0]  ex;
    logic        bd;
  } ent_t;

  ent_t        model[$];
  logic [31:0] lastPc;
  int unsigned stallModel;
  bit          doCheck = 1'b1;
  int          checkCount = 0;
  int          passCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    model.delete();
    lastPc = 32'h0000_3000;
    stallModel = 0;
  endtask

  task automatic compareAll(input logic ordy);
    bit   mv;
    bit   mir;
    ent_t f;
    mv  = model.size() > 0;
    mir = (CAP == 2) ? (model.size() < 2) : (!mv || ordy);
    if (mv) f = model[0];
    else    f = '{pc: lastPc, data: 64'd0, ex: 5'(EX_NONE), bd: 1'b0};
    checkOutput("in_ready", 64'(in_ready), 64'(mir));
    checkOutput("out_valid", 64'(out_valid), 64'(mv));
    checkOutput("out_pc", 64'(out_pc), 64'(f.pc));
    checkOutput("out_data", out_data, f.data);
    checkOutput("out_ex", 64'(out_ex), 64'(f.ex));
    checkOutput("out_bd", 64'(out_bd), 64'(f.bd));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(stallModel));
  endtask

  // Drives one cycle from a negedge, checks, advances the model, waits next negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [63:0] d,
                               input logic [4:0] ex, input logic bd, input logic fl, input logic ordy);
    bit   mv;
    bit   mir;
    ent_t e;
    in_valid = v; in_pc = pc; in_data = d; in_ex = ex; in_bd = bd;
    flush = fl; out_ready = ordy;
    #1;
    if (doCheck) compareAll(ordy);
    mv  = model.size() > 0;
    mir = (CAP == 2) ? (model.size() < 2) : (!mv || ordy);
    if (mv && !ordy && stallModel < 32'hFFFF) stallModel++;
    if (fl) model.delete();
    else begin
      if (mv && ordy) void'(model.pop_front());
      if (v && mir) begin
        e = '{pc: pc, data: d, ex: ex, bd: bd};
        model.push_back(e);
      end
    end
    if (model.size() > 0) lastPc = model[0].pc;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    modelReset();
    in_valid = 1'b1; in_pc = 32'h0000_3004; in_data = 64'hDEAD; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_pc", 64'(out_pc), 64'h3000);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset_n = 1'b1;

    applyStimulus(1'b1, 32'h0000_3004, 64'h1111_2222_3333_4444, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("first_pc", 64'(out_pc), 64'h3004);
    applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h0000_4000 + 32'(i * 4), rnd64(), 5'($urandom), 1'($urandom), 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000_5000, rnd64(), 5'd12, 1'b1, 1'b0, 1'b1);
    checkOutput("ex_field", 64'(out_ex), 64'd12);
    applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h0000_6000 + 32'(i * 4), rnd64(), 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000_7000, rnd64(), 5'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_7004, rnd64(), 5'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_7008, rnd64(), 5'd5, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), $urandom, rnd64(), 5'($urandom), 1'($urandom),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));

    applyStimulus(1'b1, 32'h0000_8000, rnd64(), 5'd0, 1'b0, 1'b0, 1'b1);
    doCheck = 1'b0;
    for (int i = 0; i < 70000; i++)
      applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    doCheck = 1'b1;
    applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_sat", 64'(stall_cnt), 64'hFFFF);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000_9000, rnd64(), 5'd7, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1; in_pc = 32'h0000_9004; out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_pc", 64'(out_pc), 64'h3000);
    checkOutput("midrst_out_ex", 64'(out_ex), 64'd0);
    checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), $urandom, rnd64(), 5'($urandom), 1'($urandom),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
